// File: rtl/ssp_cfg_update_ctrl.sv
// ssp_cfg_update_ctrl
// SSPCLK-domain configuration update controller and bit-rate prescaler.
// Toggle events on CR0UpdateSync / CPSRUpdateSync capture the quasi-static PCLK-domain
// register values into shadow registers. The shadows are applied to the live configuration
// only while the serial engine is idle or disabled, and each applied update type toggles its ack.
// A two-stage prescaler (CPSDVSR, then SCR) produces the one-cycle SSPCLKEn bit-rate strobe.
//
// Ports:
//   SSPCLK, nSSPRST                  clock, async active-low reset
//   CR0UpdateSync, CPSRUpdateSync    synchronised update toggles from PCLK domain
//   SSESync, TxRxIdle                enable and serial-engine idle status
//   SCRIn..SPHIn, CPSDVSRIn          PCLK-domain register values (stable until ack)
//   SCR..SPH, CPSDVSR                live configuration
//   CR0UpdateAck, CPSRUpdateAck      toggle acknowledges
//   UpdPending                       captured update awaiting application
//   SSPCLKEn                         bit-rate enable strobe
module ssp_cfg_update_ctrl #(
  parameter int unsigned CPSR_W = 8,
  parameter int unsigned SCR_W  = 8
) (
  input  logic              SSPCLK,
  input  logic              nSSPRST,
  input  logic              CR0UpdateSync,
  input  logic              CPSRUpdateSync,
  input  logic              SSESync,
  input  logic              TxRxIdle,
  input  logic [SCR_W-1:0]  SCRIn,
  input  logic [3:0]        DSSIn,
  input  logic [1:0]        FRFIn,
  input  logic              SPOIn,
  input  logic              SPHIn,
  input  logic [CPSR_W-1:0] CPSDVSRIn,
  output logic [SCR_W-1:0]  SCR,
  output logic [3:0]        DSS,
  output logic [1:0]        FRF,
  output logic              SPO,
  output logic              SPH,
  output logic [CPSR_W-1:0] CPSDVSR,
  output logic              CR0UpdateAck,
  output logic              CPSRUpdateAck,
  output logic              UpdPending,
  output logic              SSPCLKEn
);

  typedef enum logic [1:0] {StIdle, StWait, StApply} state_e;

  state_e              state_q, state_d;
  logic                cr0_tgl_q, cr0_tgl_d, cpsr_tgl_q, cpsr_tgl_d;
  logic                pend_cr0_q, pend_cr0_d, pend_cpsr_q, pend_cpsr_d;
  logic [SCR_W-1:0]    sh_scr_q, sh_scr_d;
  logic [3:0]          sh_dss_q, sh_dss_d;
  logic [1:0]          sh_frf_q, sh_frf_d;
  logic                sh_spo_q, sh_spo_d, sh_sph_q, sh_sph_d;
  logic [CPSR_W-1:0]   sh_cpsdvsr_q, sh_cpsdvsr_d;
  logic [SCR_W-1:0]    scr_q, scr_d;
  logic [3:0]          dss_q, dss_d;
  logic [1:0]          frf_q, frf_d;
  logic                spo_q, spo_d, sph_q, sph_d;
  logic [CPSR_W-1:0]   cpsdvsr_q, cpsdvsr_d;
  logic                cr0_ack_q, cr0_ack_d, cpsr_ack_q, cpsr_ack_d;
  logic                upd_pending_q, upd_pending_d;
  logic [CPSR_W-1:0]   pc_q, pc_d;
  logic [SCR_W-1:0]    sc_q, sc_d;
  logic                clk_en_q, clk_en_d;

  logic                cr0_evt, cpsr_evt, apply_ok, do_apply;
  logic [CPSR_W-1:0]   div_m1;

  assign cr0_evt  = CR0UpdateSync ^ cr0_tgl_q;
  assign cpsr_evt = CPSRUpdateSync ^ cpsr_tgl_q;
  assign apply_ok = !SSESync || TxRxIdle;

  always_comb begin
    state_d      = state_q;
    cr0_tgl_d    = CR0UpdateSync;
    cpsr_tgl_d   = CPSRUpdateSync;
    pend_cr0_d   = pend_cr0_q;
    pend_cpsr_d  = pend_cpsr_q;
    sh_scr_d     = sh_scr_q;
    sh_dss_d     = sh_dss_q;
    sh_frf_d     = sh_frf_q;
    sh_spo_d     = sh_spo_q;
    sh_sph_d     = sh_sph_q;
    sh_cpsdvsr_d = sh_cpsdvsr_q;
    scr_d        = scr_q;
    dss_d        = dss_q;
    frf_d        = frf_q;
    spo_d        = spo_q;
    sph_d        = sph_q;
    cpsdvsr_d    = cpsdvsr_q;
    cr0_ack_d    = cr0_ack_q;
    cpsr_ack_d   = cpsr_ack_q;
    pc_d         = pc_q;
    sc_d         = sc_q;
    clk_en_d     = 1'b0;
    do_apply     = 1'b0;

    // Live registers load on the edge that enters StApply, so they change in the same
    // cycle as the ack and two cycles after the toggle edge when the engine is idle.
    unique case (state_q)
      StIdle: begin
        if (pend_cr0_q || pend_cpsr_q) begin
          if (apply_ok) begin
            state_d  = StApply;
            do_apply = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (apply_ok) begin
          state_d  = StApply;
          do_apply = 1'b1;
        end
      end
      StApply: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (do_apply) begin
      if (pend_cr0_q) begin
        scr_d      = sh_scr_q;
        dss_d      = sh_dss_q;
        frf_d      = sh_frf_q;
        spo_d      = sh_spo_q;
        sph_d      = sh_sph_q;
        cr0_ack_d  = ~cr0_ack_q;
        pend_cr0_d = 1'b0;
      end
      if (pend_cpsr_q) begin
        cpsdvsr_d   = sh_cpsdvsr_q;
        cpsr_ack_d  = ~cpsr_ack_q;
        pend_cpsr_d = 1'b0;
      end
    end

    // Capture after apply so an event in the apply cycle keeps its pend flag.
    if (cr0_evt) begin
      sh_scr_d   = SCRIn;
      sh_dss_d   = DSSIn;
      sh_frf_d   = FRFIn;
      sh_spo_d   = SPOIn;
      sh_sph_d   = SPHIn;
      pend_cr0_d = 1'b1;
    end
    if (cpsr_evt) begin
      sh_cpsdvsr_d = {CPSDVSRIn[CPSR_W-1:1], 1'b0};
      pend_cpsr_d  = 1'b1;
    end

    upd_pending_d = pend_cr0_d | pend_cpsr_d;

    // Effective divisor is 2 when CPSDVSR is 0; reload value is divisor - 1.
    div_m1 = (cpsdvsr_d == '0) ? CPSR_W'(1) : cpsdvsr_d - CPSR_W'(1);

    if (do_apply || !SSESync) begin
      pc_d = div_m1;
      sc_d = scr_d;
    end else if (pc_q == '0) begin
      pc_d = div_m1;
      if (sc_q == '0) begin
        sc_d     = scr_d;
        clk_en_d = 1'b1;
      end else begin
        sc_d = sc_q - SCR_W'(1);
      end
    end else begin
      pc_d = pc_q - CPSR_W'(1);
    end
  end

  always_ff @(posedge SSPCLK or negedge nSSPRST) begin
    if (!nSSPRST) begin
      state_q       <= StIdle;
      cr0_tgl_q     <= 1'b0;
      cpsr_tgl_q    <= 1'b0;
      pend_cr0_q    <= 1'b0;
      pend_cpsr_q   <= 1'b0;
      sh_scr_q      <= '0;
      sh_dss_q      <= '0;
      sh_frf_q      <= '0;
      sh_spo_q      <= 1'b0;
      sh_sph_q      <= 1'b0;
      sh_cpsdvsr_q  <= '0;
      scr_q         <= '0;
      dss_q         <= '0;
      frf_q         <= '0;
      spo_q         <= 1'b0;
      sph_q         <= 1'b0;
      cpsdvsr_q     <= '0;
      cr0_ack_q     <= 1'b0;
      cpsr_ack_q    <= 1'b0;
      upd_pending_q <= 1'b0;
      pc_q          <= '0;
      sc_q          <= '0;
      clk_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cr0_tgl_q     <= cr0_tgl_d;
      cpsr_tgl_q    <= cpsr_tgl_d;
      pend_cr0_q    <= pend_cr0_d;
      pend_cpsr_q   <= pend_cpsr_d;
      sh_scr_q      <= sh_scr_d;
      sh_dss_q      <= sh_dss_d;
      sh_frf_q      <= sh_frf_d;
      sh_spo_q      <= sh_spo_d;
      sh_sph_q      <= sh_sph_d;
      sh_cpsdvsr_q  <= sh_cpsdvsr_d;
      scr_q         <= scr_d;
      dss_q         <= dss_d;
      frf_q         <= frf_d;
      spo_q         <= spo_d;
      sph_q         <= sph_d;
      cpsdvsr_q     <= cpsdvsr_d;
      cr0_ack_q     <= cr0_ack_d;
      cpsr_ack_q    <= cpsr_ack_d;
      upd_pending_q <= upd_pending_d;
      pc_q          <= pc_d;
      sc_q          <= sc_d;
      clk_en_q      <= clk_en_d;
    end
  end

  assign SCR           = scr_q;
  assign DSS           = dss_q;
  assign FRF           = frf_q;
  assign SPO           = spo_q;
  assign SPH           = sph_q;
  assign CPSDVSR       = cpsdvsr_q;
  assign CR0UpdateAck  = cr0_ack_q;
  assign CPSRUpdateAck = cpsr_ack_q;
  assign UpdPending    = upd_pending_q;
  assign SSPCLKEn      = clk_en_q;

endmodule

// File: doc/ssp_cfg_update_ctrl.md
Name: ssp_cfg_update_ctrl

Overview:
SSPCLK-domain controller that receives synchronised configuration-update toggles (CR0UpdateSync, CPSRUpdateSync) for SSPCR0 and SSPCPSR. It captures the quasi-static PCLK-domain register values into shadow registers and applies them to the live configuration only when the serial engine is idle. It then returns toggle acknowledges to the PCLK domain. It also runs the two-stage prescaler (CPSDVSR, then SCR) that produces the serial bit-rate enable strobe for the TxRx block.

Parameters:
CPSR_W, 8, width of the clock prescale divisor
SCR_W, 8, width of the serial clock rate field

Ports:
SSPCLK  input  1  main SSP clock; sole clock of the block
nSSPRST  input  1  reset, asynchronous assert, active-low
CR0UpdateSync  input  1  synchronised CR0 update toggle
CPSRUpdateSync  input  1  synchronised CPSR update toggle
SSESync  input  1  synchronised SSP enable
TxRxIdle  input  1  serial engine idle (no frame in progress)
SCRIn  input  SCR_W  SSPCR0.SCR; stable from toggle until ack
DSSIn  input  4  SSPCR0.DSS
FRFIn  input  2  SSPCR0.FRF
SPOIn  input  1  SSPCR0.SPO
SPHIn  input  1  SSPCR0.SPH
CPSDVSRIn  input  CPSR_W  SSPCPSR.CPSDVSR
SCR  output  SCR_W  live SCR
DSS  output  4  live DSS
FRF  output  2  live FRF
SPO  output  1  live SPO
SPH  output  1  live SPH
CPSDVSR  output  CPSR_W  live divisor; bit 0 always 0
CR0UpdateAck  output  1  toggles once per applied CR0 update
CPSRUpdateAck  output  1  toggles once per applied CPSR update
UpdPending  output  1  a captured update awaits application
SSPCLKEn  output  1  one-cycle bit-rate enable strobe

Behaviour:
- Reset (async, nSSPRST=0): all outputs 0; shadows 0; delayed toggle copies 0; counters 0; state IDLE.
- Detection: keep registered copies of both toggle inputs. An event is detected when an input differs from its copy. The copy updates every cycle.
- Capture: on a CR0 event, sample SCRIn, DSSIn, FRFIn, SPOIn and SPHIn into the shadow and set pend_cr0. On a CPSR event, sample CPSDVSRIn with bit 0 forced to 0 and set pend_cpsr. Both events in the same cycle capture both.
- UpdPending = pend_cr0 | pend_cpsr (registered).
- FSM IDLE: if any pend flag is set, go to APPLY when (SSESync==0 | TxRxIdle==1), else go to WAIT.
- FSM WAIT: hold until (SSESync==0 | TxRxIdle==1), then go to APPLY. Events arriving in WAIT re-capture the shadow; the latest value wins; one ack per applied type.
- FSM APPLY (one cycle): copy the pending shadow fields to the live outputs and toggle the ack of each pending type. Clear the pend flags, except that an event detected in this same cycle keeps its flag set. Reload both counters. Next state is IDLE.
- Latency: toggle edge on *Sync to live output is 2 SSPCLK cycles when the engine is idle (detect/capture, then APPLY). The ack toggles in the same cycle the live value changes.
- Prescaler effective divisor: D = CPSDVSR, or 2 if CPSDVSR==0.
- Prescaler stage 1: counter pc loads D-1 and decrements. pc==0 gives pre_tick and reloads.
- Prescaler stage 2: counter sc loads SCR and decrements on pre_tick. pc==0 & sc==0 drives SSPCLKEn=1 for one cycle and reloads sc.
- Strobe period is D*(SCR+1) SSPCLK cycles. With D=2 and SCR=0, SSPCLKEn pulses every 2nd cycle.
- Counters hold at their reload values and SSPCLKEn=0 while SSESync==0. The first strobe arrives D*(SCR+1) cycles after SSESync rises.
- Counter rollover never wraps below 0; a reload always occurs at 0.
- Reset mid-WAIT discards the pending update; no ack is issued.

Test Plan:
- Reset release, SSESync=1, no updates -> CPSDVSR=0 (D=2), SCR=0; SSPCLKEn pulses every 2 cycles; acks stay 0.
- SSESync=0; toggle CPSRUpdateSync with CPSDVSRIn=8'h0B -> 2 cycles later CPSDVSR=8'h0A and CPSRUpdateAck=1. Then SSESync=1 -> SSPCLKEn period 10.
- SCR update 8'h03 with CPSDVSR=8'h04 -> SSPCLKEn period 16 cycles. Check pulse width is exactly 1 cycle.
- SSESync=1, TxRxIdle=0; toggle CR0UpdateSync (SCRIn=5) -> UpdPending=1, SCR unchanged. Toggle again with SCRIn=7 -> still WAIT. Raise TxRxIdle -> SCR=7 next APPLY; CR0UpdateAck toggles exactly once.
- Both toggles flip in the same cycle while idle -> both fields apply in one APPLY cycle; both acks toggle together.
- Assert nSSPRST while in WAIT -> all outputs 0 immediately (async); after release there is no ack and UpdPending=0.
